// File: rtl/sched_pkg.sv
// Shared types and constants for the VOQ crossbar scheduler.
// Contents: port count/index width, port index type, FSM state enum, step count,
// and a 4-bit popcount helper used by the optional statistics counters.
package sched_pkg;

    localparam int PORT_NUM    = 4;
    localparam int PORT_W      = $clog2(PORT_NUM);
    localparam int SCHED_STEPS = 4;

    typedef logic [PORT_W-1:0] port_idx_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCHED = 2'd1,
        DONE  = 2'd2
    } sched_state_t;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        popcount4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

endpackage

// File: rtl/pick_voq.sv
// Round-robin VOQ picker: first VOQ at or after start_voq_num (wrapping) that is
// neither empty nor already claimed by another ingress this timeslot.
// Ports: start_voq_num/voq_empty/voq_picked in; voq_to_pick/no_available_voq out. Purely combinational.
import sched_pkg::*;

module pick_voq (
    input  port_idx_t             start_voq_num,
    input  logic [PORT_NUM-1:0]   voq_empty,
    input  logic [PORT_NUM-1:0]   voq_picked,
    output port_idx_t             voq_to_pick,
    output logic                  no_available_voq
);

    always_comb begin
        port_idx_t idx;
        idx              = '0;
        no_available_voq = 1'b1;
        voq_to_pick      = start_voq_num;
        for (int i = 0; i < PORT_NUM; i++) begin
            idx = start_voq_num + port_idx_t'(i);
            if (no_available_voq && !voq_empty[idx] && !voq_picked[idx]) begin
                no_available_voq = 1'b0;
                voq_to_pick      = idx;
            end
        end
    end

endmodule

// File: rtl/voq_scheduler.sv
// Per-timeslot crossbar scheduler: matches up to 4 ingress ports to distinct egress ports,
// visiting one ingress per cycle through a single time-shared pick_voq. Start at T -> sched_done at T+5.
// Ports: clk, reset_n (sync, active-low), sched_start, voq_empty_all in; sched_busy, sched_done,
// match_valid, match_egress out. Starts while busy (including the DONE cycle) are dropped.
// Optional build macro SCHED_STATS_EN adds stat_match_cnt / stat_idle_cnt counters.
import sched_pkg::*;

module voq_scheduler (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         sched_start,
    input  logic [PORT_NUM*PORT_NUM-1:0] voq_empty_all,
    output logic                         sched_busy,
    output logic                         sched_done,
    output logic [PORT_NUM-1:0]          match_valid,
    output logic [PORT_NUM*PORT_W-1:0]   match_egress
`ifdef SCHED_STATS_EN
    ,
    output logic [31:0]                  stat_match_cnt,
    output logic [31:0]                  stat_idle_cnt
`endif
);

    sched_state_t                         state_q;
    port_idx_t                            step_q;
    port_idx_t                            rot_q;
    logic [PORT_NUM-1:0][PORT_W-1:0]      prio_q;
    logic [PORT_NUM-1:0][PORT_NUM-1:0]    empty_q;
    logic [PORT_NUM-1:0]                  picked_q;
    logic [PORT_NUM-1:0]                  work_valid_q, work_valid_d;
    logic [PORT_NUM-1:0][PORT_W-1:0]      work_egress_q, work_egress_d;
    logic [PORT_NUM-1:0]                  match_valid_q;
    logic [PORT_NUM-1:0][PORT_W-1:0]      match_egress_q;
    logic                                 busy_q, done_q;
`ifdef SCHED_STATS_EN
    logic [31:0]                          stat_match_q, stat_idle_q;
`endif

    port_idx_t ing;
    port_idx_t pick;
    logic      no_avail;
    logic      grant;

    assign ing   = rot_q + step_q;
    assign grant = (state_q == SCHED) && !no_avail;

    pick_voq u_pick (
        .start_voq_num    (prio_q[ing]),
        .voq_empty        (empty_q[ing]),
        .voq_picked       (picked_q),
        .voq_to_pick      (pick),
        .no_available_voq (no_avail)
    );

    // Working match including this cycle's grant; lets the last step land
    // directly in the output registers so results are visible on the done cycle.
    always_comb begin
        work_valid_d  = work_valid_q;
        work_egress_d = work_egress_q;
        if (grant) begin
            work_valid_d[ing]  = 1'b1;
            work_egress_d[ing] = pick;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            step_q         <= '0;
            rot_q          <= '0;
            prio_q         <= '0;
            empty_q        <= '0;
            picked_q       <= '0;
            work_valid_q   <= '0;
            work_egress_q  <= '0;
            match_valid_q  <= '0;
            match_egress_q <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
`ifdef SCHED_STATS_EN
            stat_match_q   <= '0;
            stat_idle_q    <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (sched_start) begin
                        empty_q       <= voq_empty_all;
                        picked_q      <= '0;
                        work_valid_q  <= '0;
                        work_egress_q <= '0;
                        step_q        <= '0;
                        busy_q        <= 1'b1;
                        state_q       <= SCHED;
                    end
                end
                SCHED: begin
                    work_valid_q  <= work_valid_d;
                    work_egress_q <= work_egress_d;
                    if (grant) begin
                        picked_q[pick] <= 1'b1;
                        prio_q[ing]    <= pick + port_idx_t'(1);
                    end
                    step_q <= step_q + port_idx_t'(1);
                    if (step_q == port_idx_t'(SCHED_STEPS - 1)) begin
                        match_valid_q  <= work_valid_d;
                        match_egress_q <= work_egress_d;
                        done_q         <= 1'b1;
                        state_q        <= DONE;
`ifdef SCHED_STATS_EN
                        stat_match_q   <= stat_match_q + 32'(popcount4(work_valid_d));
                        stat_idle_q    <= stat_idle_q + 32'(work_valid_d == '0);
`endif
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    rot_q   <= rot_q + port_idx_t'(1);
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sched_busy   = busy_q;
    assign sched_done   = done_q;
    assign match_valid  = match_valid_q;
    assign match_egress = match_egress_q;
`ifdef SCHED_STATS_EN
    assign stat_match_cnt = stat_match_q;
    assign stat_idle_cnt  = stat_idle_q;
`endif

endmodule

// File: tb/tb_voq_scheduler.sv
// Directed bench for voq_scheduler: hand-computed matches across rotating ingress order,
// contention, dropped starts and mid-schedule reset.
// Drives and samples on the falling clock edge.
module tb_voq_scheduler;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sched_start = 1'b0;
    logic [15:0] voq_empty_all = '0;
    logic        sched_busy;
    logic        sched_done;
    logic [3:0]  match_valid;
    logic [7:0]  match_egress;
`ifdef SCHED_STATS_EN
    logic [31:0] stat_match_cnt;
    logic [31:0] stat_idle_cnt;
    logic [31:0] exp_match = '0;
    logic [31:0] exp_idle  = '0;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    voq_scheduler dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .sched_start   (sched_start),
        .voq_empty_all (voq_empty_all),
        .sched_busy    (sched_busy),
        .sched_done    (sched_done),
        .match_valid   (match_valid),
        .match_egress  (match_egress)
`ifdef SCHED_STATS_EN
        ,
        .stat_match_cnt(stat_match_cnt),
        .stat_idle_cnt (stat_idle_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_stats(input string tag, input logic [3:0] ev);
`ifdef SCHED_STATS_EN
        exp_match = exp_match + 32'($countones(ev));
        if (ev == 4'h0) exp_idle = exp_idle + 1;
        chk({tag, "_stat_match"}, stat_match_cnt, exp_match);
        chk({tag, "_stat_idle"},  stat_idle_cnt,  exp_idle);
`else
        chk({tag, "_valid_again"}, 32'(match_valid), 32'(ev));
`endif
    endtask

    // Called on a falling edge; returns on the falling edge of cycle T+6.
    task automatic run_ts(input string tag, input logic [15:0] d,
                          input logic [3:0] ev, input logic [7:0] ee);
        int dcnt;
        dcnt = 0;
        sched_start   = 1'b1;
        voq_empty_all = d;
        @(negedge clk);
        sched_start   = 1'b0;
        chk({tag, "_busy"}, 32'(sched_busy), 32'd1);
        for (int t = 1; t < 5; t++) begin
            if (sched_done) dcnt++;
            @(negedge clk);
        end
        chk({tag, "_early_done"}, 32'(dcnt), 32'd0);
        chk({tag, "_done"},   32'(sched_done),   32'd1);
        chk({tag, "_busy5"},  32'(sched_busy),   32'd1);
        chk({tag, "_valid"},  32'(match_valid),  32'(ev));
        chk({tag, "_egress"}, 32'(match_egress), 32'(ee));
        chk_stats(tag, ev);
        @(negedge clk);
        chk({tag, "_done_off"}, 32'(sched_done),   32'd0);
        chk({tag, "_idle"},     32'(sched_busy),   32'd0);
        chk({tag, "_hold"},     32'(match_egress), 32'(ee));
    endtask

    initial begin
        int dcnt;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy",   32'(sched_busy),   32'd0);
        chk("rst_done",   32'(sched_done),   32'd0);
        chk("rst_valid",  32'(match_valid),  32'd0);
        chk("rst_egress", 32'(match_egress), 32'd0);
`ifdef SCHED_STATS_EN
        chk("rst_stat_match", stat_match_cnt, 32'd0);
        chk("rst_stat_idle",  stat_idle_cnt,  32'd0);
`endif
        reset_n = 1'b1;
        @(negedge clk);

        // 1: all non-empty, rot 0, prio 0 -> ing i gets egress i
        run_ts("t1", 16'h0000, 4'hF, 8'hE4);
        // 2: rot 1, prio {0,3,2,1} -> ing1:2 ing2:3 ing3:0 ing0:1
        run_ts("t2", 16'h0000, 4'hF, 8'h39);
        // 3: all empty -> no grants, rot advances to 3
        run_ts("t3", 16'hFFFF, 4'h0, 8'h00);
        // 4: only egress 2 available everywhere; rot 3 -> ingress 3 wins
        run_ts("t4", 16'hBBBB, 4'h8, 8'h80);
        // 4b: rot 0, prio {3,0,3,2} -> ing0:2 ing1:3 ing2:0 ing3:1
        run_ts("t4b", 16'h0000, 4'hF, 8'h4E);

        // 5: starts at T+2 and on DONE are dropped; rot 1, prio {2,1,0,3}
        sched_start   = 1'b1;
        voq_empty_all = 16'h0000;
        @(negedge clk);
        sched_start   = 1'b0;
        dcnt = 0;
        for (int t = 1; t <= 5; t++) begin
            if (sched_done) dcnt++;
            if (t == 5) begin
                chk("t5_valid",  32'(match_valid),  32'hF);
                chk("t5_egress", 32'(match_egress), 32'h93);
                chk_stats("t5", 4'hF);
            end
            sched_start   = (t == 2 || t == 5);
            voq_empty_all = (t == 2 || t == 5) ? 16'hFFFF : 16'h0000;
            @(negedge clk);
        end
        sched_start = 1'b0;
        chk("t5_one_done",  32'(dcnt),       32'd1);
        chk("t5_drop_busy", 32'(sched_busy), 32'd0);
        chk("t5_drop_done", 32'(sched_done), 32'd0);
        // start at T+6 accepted: rot 2, prio {3,2,1,0}
        run_ts("t5b", 16'h0000, 4'hF, 8'hE4);

        // 6: reset at T+3 for one cycle aborts; everything back to reset values
        sched_start   = 1'b1;
        voq_empty_all = 16'h0000;
        @(negedge clk);
        sched_start   = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk("t6_busy",   32'(sched_busy),   32'd0);
        chk("t6_done",   32'(sched_done),   32'd0);
        chk("t6_valid",  32'(match_valid),  32'd0);
        chk("t6_egress", 32'(match_egress), 32'd0);
`ifdef SCHED_STATS_EN
        exp_match = '0;
        exp_idle  = '0;
        chk("t6_stat_match", stat_match_cnt, 32'd0);
        chk("t6_stat_idle",  stat_idle_cnt,  32'd0);
`endif
        dcnt = 0;
        for (int t = 0; t < 5; t++) begin
            if (sched_done || sched_busy) dcnt++;
            @(negedge clk);
        end
        chk("t6_no_done", 32'(dcnt), 32'd0);
        // rot and prio back at 0 -> identical to test 1
        run_ts("t6b", 16'h0000, 4'hF, 8'hE4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
